// File: rtl/frogger_lane_engine.sv
// Game core for the frogger playfield: game FSM, NUM_LANES wrapping obstacle lanes,
// frog/obstacle collision, lives and level bookkeeping with registered outputs.
module frogger_lane_engine #(
   parameter int         NUM_LANES   = 5,
   parameter int         GRID_W      = 14,
   parameter int         COORD_W     = 6,
   parameter int         LANE_Y0     = 11,
   parameter logic [7:0] DIR_MASK    = 8'b01010101,
   parameter int         INIT_STRIDE = 3,
   parameter int         BASE_PERIOD = 4000000,
   parameter int         LANE_SKEW   = 300000,
   parameter int         LEVEL_STEP  = 400000,
   parameter int         MIN_PERIOD  = 1000000,
   parameter int         MAX_LEVEL   = 7,
   parameter int         START_LIVES = 3,
   parameter int         HIT_CYCLES  = 25000000
) (
   input  logic                         i_Clk,
   input  logic                         i_Rst,
   input  logic                         i_Game_Start,
   input  logic [COORD_W-1:0]           i_Frog_X,
   input  logic [COORD_W-1:0]           i_Frog_Y,
   input  logic                         i_Frog_Home,
   output logic [NUM_LANES*COORD_W-1:0] o_Car_X,
   output logic [NUM_LANES*COORD_W-1:0] o_Car_Y,
   output logic                         o_Collided,
   output logic                         o_Frog_Reset,
   output logic [1:0]                   o_Lives,
   output logic [2:0]                   o_Level,
   output logic [2:0]                   o_State,
   output logic                         o_Game_Active
);

   // The slowest lane at level 0 sets the step counter width.
   localparam int SLOW_PERIOD = BASE_PERIOD + (NUM_LANES - 1) * LANE_SKEW;
   localparam int MAX_PERIOD  = (SLOW_PERIOD > MIN_PERIOD) ? SLOW_PERIOD : MIN_PERIOD;
   localparam int CNT_W       = $clog2(MAX_PERIOD + 1);
   localparam int HIT_W       = $clog2(HIT_CYCLES + 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PLAY      = 3'd1,
      ST_HIT       = 3'd2,
      ST_GAME_OVER = 3'd3
   } state_t;

   state_t             state_reg, state_next;
   logic [1:0]         lives_reg, lives_next;
   logic [2:0]         level_reg, level_next;
   logic [HIT_W-1:0]   hit_cnt_reg, hit_cnt_next;
   logic               collided_reg, collided_next;
   logic               frog_reset_reg, frog_reset_next;
   logic               game_active_reg;

   logic               lane_init;
   logic               lane_run;
   logic               hit_detect;
   logic               hit_last;
   logic [NUM_LANES-1:0] lane_hit;

   // Step period for one lane at a given level, clamped so it never drops below the floor.
   function automatic logic [31:0] lane_period(input int lane, input logic [2:0] lvl);
      int raw;
      int red;
      raw = BASE_PERIOD + lane * LANE_SKEW;
      red = int'(lvl) * LEVEL_STEP;
      if (raw >= MIN_PERIOD + red) begin
         return 32'(raw - red);
      end
      return 32'(MIN_PERIOD);
   endfunction

   assign hit_detect = (state_reg == ST_PLAY) && (|lane_hit);
   assign hit_last   = (hit_cnt_reg == HIT_W'(HIT_CYCLES - 1));

   // State register and registered outputs.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_reg       <= ST_IDLE;
         lives_reg       <= 2'(START_LIVES);
         level_reg       <= '0;
         hit_cnt_reg     <= '0;
         collided_reg    <= 1'b0;
         frog_reset_reg  <= 1'b0;
         game_active_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         lives_reg       <= lives_next;
         level_reg       <= level_next;
         hit_cnt_reg     <= hit_cnt_next;
         collided_reg    <= collided_next;
         frog_reset_reg  <= frog_reset_next;
         game_active_reg <= (state_next == ST_PLAY);
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE, ST_GAME_OVER: begin
            if (i_Game_Start) begin
               state_next = ST_PLAY;
            end
         end
         ST_PLAY: begin
            if (hit_detect) begin
               state_next = (lives_reg <= 2'd1) ? ST_GAME_OVER : ST_HIT;
            end
         end
         ST_HIT: begin
            if (hit_last) begin
               state_next = ST_PLAY;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Output / datapath control; a collision takes priority over a same-cycle home pulse.
   always_comb begin
      collided_next   = hit_detect;
      frog_reset_next = 1'b0;
      lives_next      = lives_reg;
      level_next      = level_reg;
      hit_cnt_next    = hit_cnt_reg;
      lane_init       = 1'b0;
      lane_run        = 1'b0;
      case (state_reg)
         ST_IDLE, ST_GAME_OVER: begin
            if (i_Game_Start) begin
               lives_next      = 2'(START_LIVES);
               level_next      = '0;
               frog_reset_next = 1'b1;
               lane_init       = 1'b1;
            end
         end
         ST_PLAY: begin
            if (hit_detect) begin
               lives_next   = lives_reg - 2'd1;
               hit_cnt_next = '0;
            end else begin
               lane_run = 1'b1;
               if (i_Frog_Home) begin
                  frog_reset_next = 1'b1;
                  if (level_reg != 3'(MAX_LEVEL)) begin
                     level_next = level_reg + 3'd1;
                  end
               end
            end
         end
         ST_HIT: begin
            hit_cnt_next = hit_cnt_reg + HIT_W'(1);
            if (hit_last) begin
               frog_reset_next = 1'b1;
            end
         end
         default: ;
      endcase
   end

   generate
      for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
         localparam logic [COORD_W-1:0] INIT_X = COORD_W'((gi * INIT_STRIDE) % GRID_W);
         localparam logic [COORD_W-1:0] LANE_Y = COORD_W'(LANE_Y0 - gi);
         localparam bit                 MOVE_RIGHT = DIR_MASK[gi];

         logic [COORD_W-1:0] car_x_reg;
         logic [COORD_W-1:0] car_x_step;
         logic [CNT_W-1:0]   cnt_reg;
         logic [31:0]        period;
         logic               step_due;

         always_comb begin
            period = lane_period(gi, level_reg);
         end

         // ">=" rather than "==" so a lane whose period just shrank below its count steps at once.
         assign step_due = (32'(cnt_reg) >= (period - 32'd1));

         if (MOVE_RIGHT) begin : g_right
            assign car_x_step = (car_x_reg == COORD_W'(GRID_W - 1)) ? '0 : car_x_reg + COORD_W'(1);
         end else begin : g_left
            assign car_x_step = (car_x_reg == '0) ? COORD_W'(GRID_W - 1) : car_x_reg - COORD_W'(1);
         end

         always_ff @(posedge i_Clk) begin
            if (i_Rst || lane_init) begin
               car_x_reg <= INIT_X;
               cnt_reg   <= '0;
            end else if (lane_run) begin
               if (step_due) begin
                  cnt_reg   <= '0;
                  car_x_reg <= car_x_step;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
         end

         assign lane_hit[gi] = (i_Frog_X == car_x_reg) && (i_Frog_Y == LANE_Y);
         assign o_Car_X[gi*COORD_W +: COORD_W] = car_x_reg;
         assign o_Car_Y[gi*COORD_W +: COORD_W] = LANE_Y;
      end
   endgenerate

   assign o_Collided    = collided_reg;
   assign o_Frog_Reset  = frog_reset_reg;
   assign o_Lives       = lives_reg;
   assign o_Level       = level_reg;
   assign o_State       = state_reg;
   assign o_Game_Active = game_active_reg;

endmodule

// File: tb/tb_frogger_lane_engine.sv
// Scoreboard bench for frogger_lane_engine: a cycle-level game model predicts every
// output cycle, a separate monitor pops and compares the prediction after each edge.
`timescale 1ns/1ps
module tb_frogger_lane_engine;

   localparam int NL  = 5;
   localparam int GW  = 14;
   localparam int CW  = 6;
   localparam int LY0 = 11;
   localparam int STR = 3;
   localparam int BP  = 4;
   localparam int SK  = 1;
   localparam int LS  = 1;
   localparam int MP  = 2;
   localparam int ML  = 7;
   localparam int SL  = 3;
   localparam int HC  = 5;
   localparam logic [7:0] DM = 8'b01010101;

   logic                 clk = 1'b0;
   logic                 i_Rst = 1'b1;
   logic                 i_Game_Start = 1'b0;
   logic [CW-1:0]        i_Frog_X = '0;
   logic [CW-1:0]        i_Frog_Y = '0;
   logic                 i_Frog_Home = 1'b0;
   logic [NL*CW-1:0]     o_Car_X;
   logic [NL*CW-1:0]     o_Car_Y;
   logic                 o_Collided;
   logic                 o_Frog_Reset;
   logic [1:0]           o_Lives;
   logic [2:0]           o_Level;
   logic [2:0]           o_State;
   logic                 o_Game_Active;

   always #5 clk = ~clk;

   frogger_lane_engine #(
      .NUM_LANES(NL), .GRID_W(GW), .COORD_W(CW), .LANE_Y0(LY0), .DIR_MASK(DM),
      .INIT_STRIDE(STR), .BASE_PERIOD(BP), .LANE_SKEW(SK), .LEVEL_STEP(LS),
      .MIN_PERIOD(MP), .MAX_LEVEL(ML), .START_LIVES(SL), .HIT_CYCLES(HC)
   ) dut (
      .i_Clk(clk), .i_Rst(i_Rst), .i_Game_Start(i_Game_Start),
      .i_Frog_X(i_Frog_X), .i_Frog_Y(i_Frog_Y), .i_Frog_Home(i_Frog_Home),
      .o_Car_X(o_Car_X), .o_Car_Y(o_Car_Y), .o_Collided(o_Collided),
      .o_Frog_Reset(o_Frog_Reset), .o_Lives(o_Lives), .o_Level(o_Level),
      .o_State(o_State), .o_Game_Active(o_Game_Active)
   );

   typedef struct {
      int st;
      int lives;
      int lvl;
      int col;
      int fr;
      int act;
      logic [NL*CW-1:0] carx;
   } exp_t;

   exp_t sb_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Game model: 0 idle, 1 play, 2 hit freeze, 3 game over.
   int   m_state, m_lives, m_level, m_hit_ticks, m_col, m_fr;
   int   m_x[NL];
   int   m_cnt[NL];
   logic [7:0] dir_v;

   function automatic int lane_period(input int lane, input int lvl);
      int p;
      p = BP + lane * SK - lvl * LS;
      return (p < MP) ? MP : p;
   endfunction

   task automatic model_reset();
      m_state = 0; m_lives = SL; m_level = 0; m_hit_ticks = 0; m_col = 0; m_fr = 0;
      for (int i = 0; i < NL; i++) begin
         m_x[i] = (i * STR) % GW;
         m_cnt[i] = 0;
      end
   endtask

   task automatic model_step(input bit rst, input bit start, input bit home, input int fx, input int fy);
      bit hit;
      int p;
      if (rst) begin
         model_reset();
         return;
      end
      m_col = 0;
      m_fr = 0;
      case (m_state)
         0, 3: if (start) begin
            m_lives = SL; m_level = 0; m_fr = 1; m_state = 1;
            for (int i = 0; i < NL; i++) begin
               m_x[i] = (i * STR) % GW;
               m_cnt[i] = 0;
            end
         end
         1: begin
            hit = 0;
            for (int i = 0; i < NL; i++)
               if (fx == m_x[i] && fy == LY0 - i) hit = 1;
            if (hit) begin
               m_col = 1;
               m_lives = m_lives - 1;
               m_hit_ticks = 0;
               m_state = (m_lives == 0) ? 3 : 2;
            end else begin
               for (int i = 0; i < NL; i++) begin
                  p = lane_period(i, m_level);
                  if (m_cnt[i] >= p - 1) begin
                     m_cnt[i] = 0;
                     m_x[i] = dir_v[i] ? (m_x[i] + 1) % GW : (m_x[i] + GW - 1) % GW;
                  end else begin
                     m_cnt[i] = m_cnt[i] + 1;
                  end
               end
               if (home) begin
                  m_fr = 1;
                  if (m_level < ML) m_level = m_level + 1;
               end
            end
         end
         2: begin
            m_hit_ticks = m_hit_ticks + 1;
            if (m_hit_ticks == HC) begin
               m_state = 1;
               m_fr = 1;
            end
         end
         default: ;
      endcase
   endtask

   task automatic drive(input bit rst, input bit start, input bit home, input int fx, input int fy);
      exp_t e;
      @(negedge clk);
      i_Rst        = rst;
      i_Game_Start = start;
      i_Frog_Home  = home;
      i_Frog_X     = fx[CW-1:0];
      i_Frog_Y     = fy[CW-1:0];
      model_step(rst, start, home, fx, fy);
      e.st = m_state; e.lives = m_lives; e.lvl = m_level;
      e.col = m_col; e.fr = m_fr; e.act = (m_state == 1) ? 1 : 0;
      for (int i = 0; i < NL; i++) e.carx[i*CW +: CW] = m_x[i][CW-1:0];
      sb_q.push_back(e);
   endtask

   task automatic park(input int n);
      for (int k = 0; k < n; k++) drive(0, 0, 0, $urandom_range(0, 15), 0);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, expv);
      end
   endtask

   // Monitor: one expected output vector per clock edge.
   initial begin : monitor
      exp_t e;
      logic [NL*CW-1:0] exp_y;
      int prev_st;
      prev_st = -1;
      for (int i = 0; i < NL; i++) exp_y[i*CW +: CW] = 6'(LY0 - i);
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            vectors++;
            check("state",       32'(o_State),       32'(e.st));
            check("lives",       32'(o_Lives),       32'(e.lives));
            check("level",       32'(o_Level),       32'(e.lvl));
            check("collided",    32'(o_Collided),    32'(e.col));
            check("frog_reset",  32'(o_Frog_Reset),  32'(e.fr));
            check("game_active", 32'(o_Game_Active), 32'(e.act));
            check("car_x",       32'(o_Car_X),       32'(e.carx));
            check("car_y",       32'(o_Car_Y),       32'(exp_y));
            if (e.col != 0 || e.fr != 0 || e.st != prev_st)
               $display("t=%0t txn state=%0d lives=%0d level=%0d collided=%0d frog_reset=%0d car_x=%h",
                        $time, o_State, o_Lives, o_Level, o_Collided, o_Frog_Reset, o_Car_X);
            prev_st = e.st;
         end
      end
   end

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin : stimulus
      bit rst, start, home;
      int fx, fy, lane;
      dir_v = DM;
      model_reset();
      drive(1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      // Idle: frog sitting on lane 0 and a home pulse must both be ignored.
      for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, 11);
      drive(0, 0, 1, 3, 0);
      drive(0, 1, 0, 5, 0);
      park(200);
      // Collision with lane 2, then the freeze and return.
      drive(0, 0, 0, m_x[2], 9);
      park(12);
      for (int k = 0; k < 4; k++) begin
         drive(0, 0, 1, $urandom_range(0, 15), 0);
         park($urandom_range(0, 6));
      end
      park(40);
      for (int k = 0; k < 5; k++) begin
         drive(0, 0, 1, $urandom_range(0, 15), 0);
         park($urandom_range(1, 4));
      end
      park(30);
      // Home and collision together: collision wins.
      drive(0, 0, 1, m_x[0], 11);
      park(12);
      drive(0, 0, 0, m_x[4], 7);
      park(20);
      drive(0, 0, 1, 2, 0);
      drive(0, 1, 0, 2, 0);
      park(30);
      // Reset in the middle of a hit freeze.
      drive(0, 0, 0, m_x[3], 8);
      park(2);
      drive(1, 0, 0, 4, 0);
      park(5);
      drive(0, 1, 0, 4, 0);
      park(20);
      for (int k = 0; k < 2500; k++) begin
         rst   = ($urandom_range(0, 199) == 0);
         start = ($urandom_range(0, 39) == 0);
         home  = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 9) == 0) begin
            lane = $urandom_range(0, NL - 1);
            fx = m_x[lane];
            fy = LY0 - lane;
         end else begin
            fx = $urandom_range(0, 15);
            fy = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : 0;
         end
         drive(rst, start, home, fx, fy);
      end
      repeat (3) @(negedge clk);
      if (sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected vectors left unchecked, required 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/frogger_lane_engine.md
Name: frogger_lane_engine

Overview:
Parametrised successor to the fixed five-car game core. It owns the game state machine, NUM_LANES obstacle lanes with per-lane direction and level-scaled speed, frog/obstacle collision, lives and level counting. It sits between the frog controller and the video/score blocks in the frogger top level, and exports packed obstacle coordinates for the renderer.

Parameters:
NUM_LANES, 5, number of obstacle lanes (1..8), one obstacle per lane
GRID_W, 14, playfield width in tiles; obstacle X range 0..GRID_W-1
COORD_W, 6, width of each tile coordinate
LANE_Y0, 11, tile row of lane 0; lane i sits on row LANE_Y0-i
DIR_MASK, 8'b01010101, bit i=1: lane i moves right (+X); 0: left (-X)
INIT_STRIDE, 3, lane i start X = (i*INIT_STRIDE) mod GRID_W
BASE_PERIOD, 4000000, clocks per step for lane 0 at level 0
LANE_SKEW, 300000, added period per lane index
LEVEL_STEP, 400000, period reduction per level
MIN_PERIOD, 1000000, floor on any lane period
MAX_LEVEL, 7, level saturates here
START_LIVES, 3, lives loaded on game start
HIT_CYCLES, 25000000, freeze length after a collision

Ports:
i_Clk  in  1  system clock
i_Rst  in  1  synchronous reset, active-high
i_Game_Start  in  1  level start request
i_Frog_X  in  COORD_W  frog tile column
i_Frog_Y  in  COORD_W  frog tile row
i_Frog_Home  in  1  one-cycle pulse: frog reached goal row
o_Car_X  out  NUM_LANES*COORD_W  packed obstacle X, lane i at [i*COORD_W +: COORD_W]
o_Car_Y  out  NUM_LANES*COORD_W  packed obstacle Y (constant LANE_Y0-i)
o_Collided  out  1  one-cycle pulse on collision detect
o_Frog_Reset  out  1  one-cycle pulse: frog controller returns frog to start
o_Lives  out  2  remaining lives
o_Level  out  3  current level
o_State  out  3  FSM state encoding
o_Game_Active  out  1  high only in PLAY

Behaviour:
- States: IDLE=0, PLAY=1, HIT=2, GAME_OVER=3. Reset -> IDLE; outputs: o_Lives=START_LIVES, o_Level=0, pulses 0, lane X = init X, lane counters 0.
- IDLE: lanes frozen at init X. i_Game_Start=1 -> PLAY next cycle; lives=START_LIVES, level=0, lane counters cleared, o_Frog_Reset pulses once.
- PLAY: each lane counter counts 0..P_i-1, P_i = max(MIN_PERIOD, BASE_PERIOD + i*LANE_SKEW - level*LEVEL_STEP), computed without negative underflow. On count==P_i-1: counter->0, lane steps one tile. Right lane: GRID_W-1 wraps to 0. Left lane: 0 wraps to GRID_W-1.
- Collision: registered compare of frog X/Y against every lane's current X/Y, evaluated only in PLAY. A match pulses o_Collided for exactly one cycle, decrements lives, and enters HIT. If lives was 1, it goes to 0 and the FSM enters GAME_OVER instead.
- HIT: lanes frozen, counters held. The FSM counts HIT_CYCLES clocks, then pulses o_Frog_Reset and returns to PLAY. Collision compare is masked, so no repeat hit while the frog overlaps.
- Home: i_Frog_Home in PLAY -> level+1 (saturating at MAX_LEVEL), o_Frog_Reset pulse, stay in PLAY, lane positions kept. The new period applies from the next step; the running counter is not cleared, but if counter >= new P_i-1 the lane steps on the next cycle.
- Same cycle collision and home: collision wins; the level is unchanged.
- i_Frog_Home is ignored outside PLAY.
- GAME_OVER: lanes frozen, lives=0, level held for the score display. i_Game_Start=1 -> same reinit as from IDLE -> PLAY.
- i_Rst in any state: next cycle matches the reset values; any pending pulse is cancelled.
- o_Game_Active = (state==PLAY). All outputs are registered.

Test Plan:
- Params BASE_PERIOD=4, LANE_SKEW=1, LEVEL_STEP=1, MIN_PERIOD=2, HIT_CYCLES=5, GRID_W=14. Reset, then start -> o_State=1, o_Frog_Reset one pulse. Lane0 steps X 0->1 every 4 clocks, lane1 (left) steps X 3->2 every 5 clocks.
- Right lane wrap: lane0 X 13 on its step -> 0. Left lane1 X 0 on its step -> 13.
- Frog at (X of lane2, row 9) -> o_Collided 1 cycle, lives 3->2, HIT for 5 clocks with lanes frozen. Then o_Frog_Reset pulses and the state returns to PLAY.
- Three collisions -> lives 0, o_State=3, lanes frozen. i_Game_Start -> lives 3, level 0, PLAY.
- Four i_Frog_Home pulses -> level 4. Lane0 period becomes max(2, 4-4)=2 steps; level saturates at 7 after further pulses. Home and collision in the same cycle -> level unchanged, lives-1.
- Assert i_Rst mid-HIT -> next cycle o_State=0, lives 3, lane X = init values, no o_Frog_Reset pulse.
